// File: rtl/count_monitor.sv
// count_monitor: passive observer for a 4-bit up/down counter.
// Classifies each counter step (clear, load, wrap-up, wrap-down and, optionally,
// golden-model mismatch) into timestamped records queued in a first-word
// fall-through FIFO with a valid/ready drain port. Also keeps a saturating wrap
// counter and a sticky overflow flag.
// Optional feature macro: COUNT_MONITOR_CHECK_EN (builds the golden-model comparator).
module count_monitor #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic        up,
    input  logic [3:0]  data,
    input  logic [3:0]  q,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [14:0] ev_data,
    output logic [7:0]  wrap_cnt,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned QW = 4;
    localparam int unsigned SW = 8;
    localparam int unsigned RW = 3 + QW + SW;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_CLR     = 3'd1,
        EV_LOAD    = 3'd2,
        EV_WRAP_UP = 3'd3,
        EV_WRAP_DN = 3'd4,
        EV_ERR     = 3'd5
    } ev_code_e;

    typedef struct packed {
        logic [2:0]    code;
        logic [QW-1:0] q_after;
        logic [SW-1:0] stamp;
    } ev_rec_t;

    // History of what the counter saw on the previous edge(s)
    logic [QW-1:0] q_prev;
    logic          clr_d;
    logic          load_d;
    logic          up_d;
    logic          clr_dd;
    logic          load_dd;
    logic          hist_ok;
    logic [SW-1:0] stamp;

    // Classification
    ev_code_e      base_code;
    ev_code_e      ev_code;
    ev_rec_t       rec;

    // FIFO state
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    // FIFO next-state
    logic          full;
    logic          pop;
    logic          hit;
    logic          push;
    logic          drop;
    logic          wrap_hit;
    logic [AW-1:0] rd_ptr_n;
    logic [AW-1:0] wr_ptr_n;
    logic [CW-1:0] count_n;
    logic [RW-1:0] head_n;
    logic          ovf_n;

    // Capture the counter controls and output every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev  <= '0;
            clr_d   <= 1'b0;
            load_d  <= 1'b0;
            up_d    <= 1'b0;
            clr_dd  <= 1'b0;
            load_dd <= 1'b0;
            hist_ok <= 1'b0;
        end else begin
            q_prev  <= q;
            clr_d   <= clr;
            load_d  <= load;
            up_d    <= up;
            clr_dd  <= clr_d;
            load_dd <= load_d;
            hist_ok <= 1'b1;
        end
    end

    // Free-running record timestamp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + SW'(1);
        end
    end

    // Priority classification of the step from q_prev to q (without the comparator)
    always_comb begin
        base_code = EV_NONE;
        if (hist_ok) begin
            if (clr_d && !clr_dd) begin
                base_code = EV_CLR;
            end else if (load_d && !load_dd && !clr_d) begin
                base_code = EV_LOAD;
            end else if (!clr_d && !load_d) begin
                if (up_d && (q_prev == 4'hF) && (q == 4'h0)) begin
                    base_code = EV_WRAP_UP;
                end else if (!up_d && (q_prev == 4'h0) && (q == 4'hF)) begin
                    base_code = EV_WRAP_DN;
                end
            end
        end
    end

`ifdef COUNT_MONITOR_CHECK_EN
    logic [QW-1:0] data_d;
    logic [QW-1:0] exp_q;
    logic          mismatch;

    // Load value seen by the counter on the previous edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_d <= '0;
        end else begin
            data_d <= data;
        end
    end

    // Golden counter: what q should be after the previous edge's controls
    always_comb begin
        exp_q = q_prev;
        if (clr_d) begin
            exp_q = '0;
        end else if (load_d) begin
            exp_q = data_d;
        end else if (up_d) begin
            exp_q = q_prev + QW'(1);
        end else begin
            exp_q = q_prev - QW'(1);
        end
    end

    assign mismatch = hist_ok && (q != exp_q);
    assign ev_code  = mismatch ? EV_ERR : base_code;
`else
    logic unused_data;

    // The load value only matters to the comparator
    assign unused_data = &{1'b0, data};
    assign ev_code     = base_code;
`endif

    assign rec = '{code: ev_code, q_after: q, stamp: stamp};

    // FIFO push/pop decisions and the next head for the registered output
    always_comb begin
        full     = (count == CW'(DEPTH));
        pop      = ev_valid && ev_ready;
        hit      = (ev_code != EV_NONE);
        push     = hit && (!full || pop);
        drop     = hit && full && !pop;
        wrap_hit = (ev_code == EV_WRAP_UP) || (ev_code == EV_WRAP_DN);
        rd_ptr_n = rd_ptr + AW'(pop);
        wr_ptr_n = wr_ptr + AW'(push);
        count_n  = count + CW'(push) - CW'(pop);
        head_n   = ev_data;
        if (count_n != '0) begin
            if (push && (count == CW'(pop))) begin
                head_n = rec;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
        ovf_n = ovf;
        if (drop) begin
            ovf_n = 1'b1;
        end else if (ovf_clr) begin
            ovf_n = 1'b0;
        end
    end

    // Record storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec;
        end
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ev_valid <= 1'b0;
            ev_data  <= '0;
        end else begin
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr_n;
            count    <= count_n;
            ev_valid <= (count_n != '0);
            ev_data  <= head_n;
        end
    end

    // Saturating wrap counter and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wrap_hit && (wrap_cnt != 8'hFF)) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
            ovf <= ovf_n;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: a counter stub drives q, a behavioural model keeps
// a sample history and an expected-record queue, and a monitor pops and compares
// every handshake. Directed phases follow the event rules, then random traffic.
module tb_count_monitor;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        up = 1'b0;
    logic [3:0]  data = 4'd0;
    logic [3:0]  q;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [14:0] ev_data;
    logic [7:0]  wrap_cnt;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    logic [3:0]  cnt;
    logic        stub = 1'b0;
    logic [3:0]  stub_val = 4'd0;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit       clr;
        bit       load;
        bit       up;
        bit [3:0] data;
        bit [3:0] q;
    } samp_t;

    // Model state
    samp_t        h1;
    samp_t        h2;
    int           nsamp;
    int unsigned  edges;
    int           m_cnt;
    int           m_wrap;
    bit           m_ovf;
    logic [14:0]  sb[$];

    count_monitor #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .up       (up),
        .data     (data),
        .q        (q),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .wrap_cnt (wrap_cnt),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // The counter being observed: clr > load > count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= 4'd0;
        else if (clr)   cnt <= 4'd0;
        else if (load)  cnt <= data;
        else if (up)    cnt <= cnt + 4'd1;
        else            cnt <= cnt - 4'd1;
    end

    assign q = stub ? stub_val : cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        h1 = '{default: 0};
        h2 = '{default: 0};
        nsamp = 0;
        edges = 0;
        m_cnt = 0;
        m_wrap = 0;
        m_ovf = 1'b0;
        sb.delete();
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge();
        samp_t    cur;
        bit       pop;
        bit       drop;
        bit [2:0] code;
`ifdef COUNT_MONITOR_CHECK_EN
        bit [3:0] expq;
`endif
        cur = '{clr: clr, load: load, up: up, data: data, q: q};
        pop = (m_cnt > 0) && ev_ready;
        drop = 1'b0;
        code = 3'd0;
        if (nsamp >= 1) begin
`ifdef COUNT_MONITOR_CHECK_EN
            if (h1.clr)       expq = 4'd0;
            else if (h1.load) expq = h1.data;
            else if (h1.up)   expq = h1.q + 4'd1;
            else              expq = h1.q - 4'd1;
            if (cur.q != expq) code = 3'd5;
`endif
            if (code == 3'd0) begin
                if (h1.clr && !h2.clr)                  code = 3'd1;
                else if (h1.load && !h2.load && !h1.clr) code = 3'd2;
                else if (!h1.clr && !h1.load) begin
                    if (h1.up && h1.q == 4'hF && cur.q == 4'h0)       code = 3'd3;
                    else if (!h1.up && h1.q == 4'h0 && cur.q == 4'hF) code = 3'd4;
                end
            end
        end
        if (code != 3'd0) begin
            if ((code == 3'd3 || code == 3'd4) && m_wrap < 255) m_wrap++;
            if (m_cnt < int'(DEPTH) || pop) begin
                sb.push_back({code, cur.q, edges[7:0]});
                m_cnt++;
            end else begin
                drop = 1'b1;
            end
        end
        if (pop) m_cnt--;
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        h2 = h1;
        h1 = cur;
        if (nsamp < 2) nsamp++;
        edges++;
    endtask

    task automatic model_proc();
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    endtask

    // Scoreboard monitor: compares status every cycle and the head on each handshake
    task automatic monitor_proc();
        logic [14:0] exp;
        forever begin
            @(negedge clk);
            chk("ev_valid", 32'(ev_valid), 32'(sb.size() != 0));
            chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ev_pop actual=%0h required=no_record t=%0t", ev_data, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("ev_data", 32'(ev_data), 32'(exp));
                end
            end
        end
    endtask

    // Advance n edges; returns 2 time units after the last edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        fork
            model_proc();
            monitor_proc();
        join_none

        cyc(3);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_data", 32'(ev_data), 32'd0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Clear pulse, then count down from 0 to wrap
        rst_n = 1'b1;
        ev_ready = 1'b1;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        up = 1'b0;
        data = 4'd12;
        cyc(6);

        // Held load yields a single LOAD record, then count up from C
        load = 1'b1;
        data = 4'd12;
        cyc(3);
        load = 1'b0;
        up = 1'b1;
        cyc(8);

        // Overflow with the consumer stalled, then clear the sticky flag
        ev_ready = 1'b1;
        cyc(4);
        ev_ready = 1'b0;
        cyc(16 * (DEPTH + 1) + 4);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        cyc(1);

        // Full FIFO: accept only in the detection cycle of a wrap
        for (int i = 0; i < 40; i++) begin
            ev_ready = (q == 4'h0);
            cyc(1);
        end
        ev_ready = 1'b1;
        cyc(6);

        // Counter output stuck at 5 while counting up
        stub_val = 4'd5;
        stub = 1'b1;
        up = 1'b1;
        cyc(10);
        stub = 1'b0;
        cyc(4);

        // Queue three LOAD records, then reset mid-stream
        ev_ready = 1'b0;
        data = 4'd3;
        for (int i = 0; i < 3; i++) begin
            load = 1'b1;
            cyc(1);
            load = 1'b0;
            cyc(2);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ev_valid", 32'(ev_valid), 32'd0);
        chk("midrst_wrap_cnt", 32'(wrap_cnt), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_ev_data", 32'(ev_data), 32'd0);
        stub_val = 4'hF;
        stub = 1'b1;
        up = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        cyc(1);
        chk("first_edge_no_event", 32'(ev_valid), 32'd0);
        stub = 1'b0;
        cyc(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 99) < 5);
            load = ($urandom_range(0, 99) < 10);
            up = 1'($urandom_range(0, 1));
            data = 4'($urandom_range(0, 15));
            ev_ready = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 85));
            ovf_clr = ($urandom_range(0, 99) < 5);
            stub = ($urandom_range(0, 99) < 3);
            stub_val = 4'($urandom_range(0, 15));
            cyc(1);
        end
        clr = 1'b0;
        load = 1'b0;
        stub = 1'b0;
        ovf_clr = 1'b0;
        ev_ready = 1'b1;
        cyc(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Passive observer placed directly downstream of the 4-bit up/down counter. It samples the same `clr`/`load`/`up`/`data` controls the counter sees plus the counter's `Q`, and classifies each counter step: clear, load, wrap-up, wrap-down, or (optionally) mismatch against a golden model. Each classified event becomes a timestamped record in a small FIFO, drained through a valid/ready port, and the block keeps a saturating wrap counter.

## Interface
- `DEPTH`, 4: event FIFO entries, power of two, ≥2
- `clk` input 1: clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `clr` input 1: counter synchronous clear, as driven to the counter
- `load` input 1: counter load, as driven to the counter
- `up` input 1: counter direction (1 = up, 0 = down)
- `data` input 4: counter load value
- `q` input 4: counter output `Q`
- `ev_valid` output 1: FIFO head holds a record
- `ev_ready` input 1: consumer accepts head
- `ev_data` output 15: record {code[14:12], q_after[11:8], stamp[7:0]}
- `wrap_cnt` output 8: wrap events seen, saturates at 255
- `ovf` output 1: sticky; record dropped on full FIFO
- `ovf_clr` input 1: clears `ovf`

## Operation
- The counter model is decided: `clr` > `load` > count. Count is +1 when `up`, else −1, both mod 16, and the counter counts every cycle.
- History registers: `q_prev`, `clr_d`, `load_d`, `up_d`, `data_d` capture inputs every edge. `load_dd` and `clr_dd` hold the previous `load_d` and `clr_d`. `hist_ok` is set on the first edge after reset.
- Each cycle with `hist_ok`=1, evaluate before = `q_prev`, after = `q`, cause = the `*_d` registers. The first priority that matches emits exactly one event:
  - ERR, code 5: only with the macro; after ≠ expected(before, cause).
  - CLR, code 1: `clr_d` & !`clr_dd`, i.e. rising edge of clear only.
  - LOAD, code 2: `load_d` & !`load_dd` & !`clr_d`.
  - WRAP_UP, code 3: no clr/load, `up_d`, before=F, after=0.
  - WRAP_DN, code 4: no clr/load, !`up_d`, before=0, after=F.
- Codes 0, 6 and 7 are never produced.
- `stamp`: a free-running 8-bit cycle counter, 0 after reset, that wraps 255→0. The record takes the stamp value in the cycle the event is detected.
- `wrap_cnt` increments on codes 3 and 4 and saturates at 255. It increments even if the record is dropped.
- FIFO uses first-word fall-through, with `ev_data` = head when `ev_valid`. Pop occurs on `ev_valid & ev_ready`.
- Full and event in the same cycle:
  - With a pop in that cycle, the push is accepted.
  - Without a pop, the record is dropped and `ovf` is set.
- `ovf_clr` and a new overflow in the same cycle: `ovf` stays 1.
- Empty FIFO with `ev_ready`=1: no effect.

## Timing
- Reset values: `ev_valid`=0, `ev_data`=0, `wrap_cnt`=0, `ovf`=0, FIFO empty, stamp=0, `hist_ok`=0, all history registers 0.
- Latency: the counter updates at edge E. The monitor detects at edge E+1, and `ev_valid` rises after E+1 if the FIFO was empty. `wrap_cnt` also updates at E+1.
- No event is generated from the edge that sets `hist_ok`.
- `rst_n` asserted mid-operation: everything returns to reset values immediately and asynchronously. Pending records are lost, and `hist_ok` must be re-earned.
- Handshake: `ev_data` is stable while `ev_valid`=1 and `ev_ready`=0. Back-to-back pops at one per cycle are supported.

## Configuration
- `COUNT_MONITOR_CHECK_EN` defined:
  - The golden-model comparator is built. Expected value = 0 if clr, `data_d` if load, before±1 mod 16 otherwise.
  - A mismatch emits ERR and suppresses lower-priority codes that cycle.
- Not defined:
  - No comparator logic.
  - Code 5 is never produced.
  - All other behaviour is identical.

## Test plan
- Reset release; `clr`=1 for 1 cycle, then `up`=0, `data`=12 → one CLR record {1, 0, stamp} and no other events. After 1 more cycle Q goes 0→F, giving WRAP_DN {4, F, stamp}, and `wrap_cnt`=1.
- `load`=1 held 3 cycles with `data`=12 → exactly one LOAD record {2, C, ·}. Releasing with `up`=1 from C → WRAP_UP {3, 0, ·} 4 cycles after release.
- `ev_ready`=0 with wraps forced (up, 16 cycles per wrap) until DEPTH+1 events → `ovf`=1 and FIFO holds the first DEPTH records. Pulsing `ovf_clr` → `ovf`=0.
- Full FIFO with `ev_ready`=1 and an event in the same cycle → push accepted, count unchanged, no `ovf`.
- With the macro: drive `q` from a stub holding 5 while `up`=1 → ERR {5, 5, ·} every cycle. Without the macro → no records.
- `rst_n` pulsed low mid-stream with 3 records queued → `ev_valid`=0, `wrap_cnt`=0 immediately, and no event on the first edge after release.
